// File: rtl/zeroriscy_exc_controller_pkg.sv
// Shared definitions for the zero-riscy exception controller: trap cause
// codes, fetch-target encodings, FSM state type and the priority encoder
// used to pick one synchronous exception when several flags are raised.
package zeroriscy_exc_controller_pkg;

    // mcause codes for synchronous exceptions
    localparam logic [4:0] EXC_CAUSE_ILLEGAL_INSN = 5'd2;
    localparam logic [4:0] EXC_CAUSE_BREAKPOINT   = 5'd3;
    localparam logic [4:0] EXC_CAUSE_LOAD_FAULT   = 5'd5;
    localparam logic [4:0] EXC_CAUSE_STORE_FAULT  = 5'd7;
    localparam logic [4:0] EXC_CAUSE_ECALL_MMODE  = 5'd11;

    // Fetch target select driven to the IF stage together with pc_set
    localparam logic [1:0] EXC_PC_EXC  = 2'd0;
    localparam logic [1:0] EXC_PC_IRQ  = 2'd1;
    localparam logic [1:0] EXC_PC_MEPC = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } exc_ctrl_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] code;
    } exc_sel_t;

    // Priority encoder: load fault > store fault > illegal > ecall > ebreak
    function automatic exc_sel_t exc_select(
        input logic load_err,
        input logic store_err,
        input logic illegal,
        input logic ecall,
        input logic ebrk
    );
        exc_sel_t sel;
        sel.valid = load_err | store_err | illegal | ecall | ebrk;
        if (load_err) begin
            sel.code = EXC_CAUSE_LOAD_FAULT;
        end else if (store_err) begin
            sel.code = EXC_CAUSE_STORE_FAULT;
        end else if (illegal) begin
            sel.code = EXC_CAUSE_ILLEGAL_INSN;
        end else if (ecall) begin
            sel.code = EXC_CAUSE_ECALL_MMODE;
        end else if (ebrk) begin
            sel.code = EXC_CAUSE_BREAKPOINT;
        end else begin
            sel.code = 5'd0;
        end
        return sel;
    endfunction

endpackage

// File: rtl/zeroriscy_exc_controller_irq_sync.sv
// IRQ sample stage for the exception controller. With the macro
// ZERORISCY_IRQ_SYNC_EN defined the request and its ID pass through a
// two-flop synchronizer (irq_i may be asynchronous); otherwise a single
// register stage is used and irq_i must be synchronous to clk. The ID is
// always captured in lock-step with the request bit.
module zeroriscy_irq_sync #(
    parameter int unsigned ID_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq_i,
    input  logic [ID_W-1:0] irq_id_i,
    output logic            irq_q_o,
    output logic [ID_W-1:0] irq_id_q_o
);

    logic            irq_q;
    logic [ID_W-1:0] irq_id_q;

`ifdef ZERORISCY_IRQ_SYNC_EN
    logic            irq_meta_q;
    logic [ID_W-1:0] irq_id_meta_q;

    // Two-stage synchronizer for request and ID
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_meta_q    <= 1'b0;
            irq_id_meta_q <= '0;
            irq_q         <= 1'b0;
            irq_id_q      <= '0;
        end else begin
            irq_meta_q    <= irq_i;
            irq_id_meta_q <= irq_id_i;
            irq_q         <= irq_meta_q;
            irq_id_q      <= irq_id_meta_q;
        end
    end
`else
    // Single register stage for a synchronous request
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            irq_q    <= irq_i;
            irq_id_q <= irq_id_i;
        end
    end
`endif

    assign irq_q_o    = irq_q;
    assign irq_id_q_o = irq_id_q;

endmodule

// File: rtl/zeroriscy_exc_controller.sv
// zero-riscy trap sequencer. Arbitrates synchronous exceptions, MRET and
// external interrupts in IDLE, drives the CSR save/restore strobes, the IF
// redirect selects and the interrupt acknowledge, then sits in WAIT for
// WAIT_CYCLES quiet cycles. Optional macro ZERORISCY_IRQ_SYNC_EN selects a
// two-flop synchronizer on the interrupt inputs (see zeroriscy_irq_sync).
module zeroriscy_exc_controller
    import zeroriscy_exc_controller_pkg::*;
#(
    parameter int unsigned N_IRQ_ID_W  = 5,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  irq_i,
    input  logic [N_IRQ_ID_W-1:0] irq_id_i,
    input  logic                  m_irq_enable_i,
    input  logic                  instr_valid_i,
    input  logic                  id_ready_i,
    input  logic                  illegal_insn_i,
    input  logic                  ecall_insn_i,
    input  logic                  ebrk_insn_i,
    input  logic                  mret_insn_i,
    input  logic                  lsu_load_err_i,
    input  logic                  lsu_store_err_i,
    output logic                  csr_save_cause_o,
    output logic                  csr_save_if_o,
    output logic                  csr_save_id_o,
    output logic                  csr_restore_mret_o,
    output logic [5:0]            csr_cause_o,
    output logic                  pc_set_o,
    output logic [1:0]            exc_pc_mux_o,
    output logic [4:0]            exc_vec_pc_mux_o,
    output logic                  halt_if_o,
    output logic                  flush_id_o,
    output logic                  irq_ack_o,
    output logic [4:0]            irq_id_o
);

    // Last count value in WAIT before returning to IDLE
    localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYCLES - 1);

    exc_ctrl_state_e       state_q, state_d;
    logic [1:0]            wait_cnt_q, wait_cnt_d;
    logic                  irq_q;
    logic [N_IRQ_ID_W-1:0] irq_id_q;
    logic [4:0]            irq_id_ext;
    exc_sel_t              exc_sel;
    logic                  exc_take, mret_take, irq_take;

    zeroriscy_irq_sync #(
        .ID_W (N_IRQ_ID_W)
    ) u_irq_sync (
        .clk        (clk),
        .rst        (rst),
        .irq_i      (irq_i),
        .irq_id_i   (irq_id_i),
        .irq_q_o    (irq_q),
        .irq_id_q_o (irq_id_q)
    );

    // Trap arbitration: exception beats MRET beats interrupt
    assign irq_id_ext = 5'(irq_id_q);
    assign exc_sel    = exc_select(lsu_load_err_i, lsu_store_err_i,
                                   illegal_insn_i, ecall_insn_i, ebrk_insn_i);
    assign exc_take   = instr_valid_i & exc_sel.valid;
    assign mret_take  = instr_valid_i & mret_insn_i & ~exc_take;
    assign irq_take   = irq_q & m_irq_enable_i & id_ready_i & ~exc_take & ~mret_take;

    // State and quiet-cycle counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state: any trap enters WAIT, WAIT leaves after WAIT_CYCLES cycles
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = 2'd0;
                if (exc_take | mret_take | irq_take) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = IDLE;
                    wait_cnt_d = 2'd0;
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 2'd0;
            end
        endcase
    end

    // Outputs: single-cycle trap strobes in IDLE, halt/flush held in WAIT
    always_comb begin
        csr_save_cause_o   = 1'b0;
        csr_save_if_o      = 1'b0;
        csr_save_id_o      = 1'b0;
        csr_restore_mret_o = 1'b0;
        csr_cause_o        = 6'd0;
        pc_set_o           = 1'b0;
        exc_pc_mux_o       = EXC_PC_EXC;
        exc_vec_pc_mux_o   = 5'd0;
        halt_if_o          = 1'b0;
        flush_id_o         = 1'b0;
        irq_ack_o          = 1'b0;
        irq_id_o           = 5'd0;
        case (state_q)
            IDLE: begin
                if (exc_take) begin
                    csr_save_cause_o = 1'b1;
                    csr_save_id_o    = 1'b1;
                    csr_cause_o      = {1'b0, exc_sel.code};
                    pc_set_o         = 1'b1;
                    exc_pc_mux_o     = EXC_PC_EXC;
                    exc_vec_pc_mux_o = 5'd0;
                    flush_id_o       = 1'b1;
                end else if (mret_take) begin
                    csr_restore_mret_o = 1'b1;
                    pc_set_o           = 1'b1;
                    exc_pc_mux_o       = EXC_PC_MEPC;
                    flush_id_o         = 1'b1;
                end else if (irq_take) begin
                    csr_save_cause_o = 1'b1;
                    csr_save_if_o    = 1'b1;
                    csr_cause_o      = {1'b1, irq_id_ext};
                    pc_set_o         = 1'b1;
                    exc_pc_mux_o     = EXC_PC_IRQ;
                    exc_vec_pc_mux_o = irq_id_ext;
                    irq_ack_o        = 1'b1;
                    irq_id_o         = irq_id_ext;
                end else begin
                    halt_if_o = 1'b0;
                end
            end
            WAIT: begin
                halt_if_o  = 1'b1;
                flush_id_o = 1'b1;
            end
            default: begin
                halt_if_o  = 1'b0;
                flush_id_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_zeroriscy_exc_controller.sv
// Self-checking bench for zeroriscy_exc_controller: directed scenarios
// followed by random stimulus, all checked against a cycle-level model of
// the trap rules (quiet-cycle countdown plus an IRQ sample pipeline).
module tb_zeroriscy_exc_controller;
    import zeroriscy_exc_controller_pkg::*;

    localparam int WAITC = 2;

    typedef struct packed {
        logic       save_cause;
        logic       save_if;
        logic       save_id;
        logic       restore;
        logic [5:0] cause;
        logic       pc_set;
        logic [1:0] mux;
        logic [4:0] vec;
        logic       halt;
        logic       flush;
        logic       ack;
        logic [4:0] irq_id;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       irq_i = 1'b0;
    logic [4:0] irq_id_i = 5'd0;
    logic       mie = 1'b0, valid = 1'b0, ready = 1'b0;
    logic       illegal = 1'b0, ecall = 1'b0, ebrk = 1'b0, mret = 1'b0;
    logic       ld_err = 1'b0, st_err = 1'b0;

    logic       save_cause, save_if, save_id, restore, pc_set, halt, flush, ack;
    logic [5:0] cause;
    logic [1:0] mux;
    logic [4:0] vec, ack_id;

    int    n_checks = 0;
    int    n_fail   = 0;
    outs_t last_obs;

    // model state
    int         m_quiet = 0;
    logic       m_irq = 1'b0, m_irq_s = 1'b0;
    logic [4:0] m_id = 5'd0, m_id_s = 5'd0;

    zeroriscy_exc_controller #(.N_IRQ_ID_W(5), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst), .irq_i(irq_i), .irq_id_i(irq_id_i),
        .m_irq_enable_i(mie), .instr_valid_i(valid), .id_ready_i(ready),
        .illegal_insn_i(illegal), .ecall_insn_i(ecall), .ebrk_insn_i(ebrk),
        .mret_insn_i(mret), .lsu_load_err_i(ld_err), .lsu_store_err_i(st_err),
        .csr_save_cause_o(save_cause), .csr_save_if_o(save_if),
        .csr_save_id_o(save_id), .csr_restore_mret_o(restore),
        .csr_cause_o(cause), .pc_set_o(pc_set), .exc_pc_mux_o(mux),
        .exc_vec_pc_mux_o(vec), .halt_if_o(halt), .flush_id_o(flush),
        .irq_ack_o(ack), .irq_id_o(ack_id)
    );

    always #5 clk = ~clk;

    function automatic outs_t observe();
        return {save_cause, save_if, save_id, restore, cause, pc_set, mux,
                vec, halt, flush, ack, ack_id};
    endfunction

    // Expected outputs this cycle from the trap rules
    function automatic outs_t model_expect();
        outs_t e;
        logic [4:0] flags;
        int codes [5];
        e = '0;
        flags = {ld_err, st_err, illegal, ecall, ebrk};
        codes = '{5, 7, 2, 11, 3};
        if (m_quiet > 0) begin
            e.halt  = 1'b1;
            e.flush = 1'b1;
        end else if (valid && flags != 5'd0) begin
            for (int i = 0; i < 5; i++) begin
                if (flags[4-i] && !e.pc_set) begin
                    e.cause = 6'(codes[i]);
                    e.pc_set = 1'b1;
                end
            end
            e.save_cause = 1'b1;
            e.save_id    = 1'b1;
            e.mux        = EXC_PC_EXC;
            e.flush      = 1'b1;
        end else if (valid && mret) begin
            e.restore = 1'b1;
            e.pc_set  = 1'b1;
            e.mux     = EXC_PC_MEPC;
            e.flush   = 1'b1;
        end else if (m_irq && mie && ready) begin
            e.save_cause = 1'b1;
            e.save_if    = 1'b1;
            e.cause      = {1'b1, m_id};
            e.pc_set     = 1'b1;
            e.mux        = EXC_PC_IRQ;
            e.vec        = m_id;
            e.ack        = 1'b1;
            e.irq_id     = m_id;
        end
        return e;
    endfunction

    task automatic model_update(input logic trap);
        if (rst) begin
            m_quiet = 0;
            m_irq = 1'b0; m_irq_s = 1'b0; m_id = 5'd0; m_id_s = 5'd0;
        end else begin
            if (m_quiet > 0) m_quiet = m_quiet - 1;
            else if (trap) m_quiet = WAITC;
`ifdef ZERORISCY_IRQ_SYNC_EN
            m_irq = m_irq_s; m_id = m_id_s;
            m_irq_s = irq_i; m_id_s = irq_id_i;
`else
            m_irq = irq_i; m_id = irq_id_i;
`endif
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance model at the edge
    task automatic step();
        outs_t e, o;
        #4;
        e = model_expect();
        o = observe();
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL outs t=%0t observed=%h expected=%h", $time, o, e);
        end
        last_obs = o;
        @(posedge clk);
        model_update(e.pc_set);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_flags();
        valid = 1'b0; illegal = 1'b0; ecall = 1'b0; ebrk = 1'b0;
        mret = 1'b0; ld_err = 1'b0; st_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_update(1'b0);
        #1;
        rst = 1'b0;

        // reset state
        step();
        check("reset_zero", 8'(last_obs == '0), 8'd1);

        // illegal instruction
        valid = 1'b1; illegal = 1'b1;
        step();
        check("ill_cause", 8'(last_obs.cause), 8'h02);
        check("ill_save", {6'd0, last_obs.save_cause, last_obs.save_id}, 8'h03);
        check("ill_pcset", 8'(last_obs.pc_set), 8'd1);
        check("ill_mux", 8'(last_obs.mux), 8'(EXC_PC_EXC));
        clear_flags();
        step(); check("ill_halt1", 8'(last_obs.halt), 8'd1);
        step(); check("ill_halt2", 8'(last_obs.halt), 8'd1);
        step(); check("ill_halt_end", 8'(last_obs.halt), 8'd0);

        // interrupt id 9
        irq_i = 1'b1; irq_id_i = 5'd9; mie = 1'b1; ready = 1'b1;
        step();
`ifdef ZERORISCY_IRQ_SYNC_EN
        step();
`endif
        check("irq_early", 8'(last_obs.ack), 8'd0);
        step();
        check("irq_ack", 8'(last_obs.ack), 8'd1);
        check("irq_id", 8'(last_obs.irq_id), 8'd9);
        check("irq_cause", 8'(last_obs.cause), 8'h29);
        check("irq_save_if", 8'(last_obs.save_if), 8'd1);
        check("irq_vec", 8'(last_obs.vec), 8'd9);
        irq_i = 1'b0; mie = 1'b0;
        step(); step(); step();

        // everything at once: load fault wins, no ack
        irq_i = 1'b1; mie = 1'b1; ready = 1'b0;
        step(); step();
        valid = 1'b1; ld_err = 1'b1; illegal = 1'b1; ecall = 1'b1; ready = 1'b1;
        step();
        check("multi_cause", 8'(last_obs.cause), 8'h05);
        check("multi_ack", 8'(last_obs.ack), 8'd0);
        clear_flags(); mie = 1'b0;
        step(); step(); step();
        check("pend_noack", 8'(last_obs.ack), 8'd0);
        irq_i = 1'b0;
        step(); step();

        // MRET
        valid = 1'b1; mret = 1'b1;
        step();
        check("mret_restore", 8'(last_obs.restore), 8'd1);
        check("mret_mux", 8'(last_obs.mux), 8'(EXC_PC_MEPC));
        check("mret_nosave", {5'd0, last_obs.save_cause, last_obs.save_if, last_obs.save_id}, 8'd0);
        clear_flags();
        step(); step(); step();
        check("mret_pulse", 8'(last_obs.restore), 8'd0);

        // MIE gating
        irq_i = 1'b1; irq_id_i = 5'd17; mie = 1'b0; ready = 1'b1;
        repeat (10) step();
        check("mie0_noack", 8'(last_obs.ack), 8'd0);
        mie = 1'b1;
        step();
        check("mie1_ack", 8'(last_obs.ack), 8'd1);
        irq_i = 1'b0; mie = 1'b0;
        step(); step();

        // reset during WAIT, then ecall
        valid = 1'b1; ecall = 1'b1;
        step();
        clear_flags(); rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("rst_wait_zero", 8'(last_obs == '0), 8'd1);
        valid = 1'b1; ecall = 1'b1;
        step();
        check("ecall_cause", 8'(last_obs.cause), 8'h0B);
        clear_flags();
        step(); step(); step();

        // random stimulus
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(49, 0) == 0);
            valid    = ($urandom_range(1, 0) == 1);
            illegal  = ($urandom_range(7, 0) == 0);
            ecall    = ($urandom_range(7, 0) == 0);
            ebrk     = ($urandom_range(7, 0) == 0);
            mret     = ($urandom_range(7, 0) == 0);
            ld_err   = ($urandom_range(9, 0) == 0);
            st_err   = ($urandom_range(9, 0) == 0);
            mie      = ($urandom_range(1, 0) == 1);
            ready    = ($urandom_range(3, 0) != 0);
            if ($urandom_range(3, 0) == 0) irq_i = ~irq_i;
            irq_id_i = 5'($urandom_range(31, 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
